// File: rtl/serializer_pkg.sv
// Shared types and constants for the byte serializer and its interface.
package serializer_pkg;

    // Default byte width; matches the upstream queue data width.
    localparam int unsigned DATA_WIDTH_DEFAULT = 8;

    // Width of the queue occupancy bus.
    localparam int unsigned LEN_WIDTH = 8;

    // Width of the transmitted-byte counter.
    localparam int unsigned COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/byte_serializer_if.sv
// Queue-side and serial-side signal bundle for the byte serializer.
// The slave modport is the serializer's view; master is the environment's view.
interface byte_serializer_if #(
    parameter int unsigned DATA_WIDTH = serializer_pkg::DATA_WIDTH_DEFAULT
);
    import serializer_pkg::*;

    // Queue side
    logic                   enable_in;
    logic [LEN_WIDTH-1:0]   len_in;
    logic [DATA_WIDTH-1:0]  data_in;
    logic                   dequeue_out;

    // Serial side
    logic                   serial_ready_in;
    logic                   serial_out;
    logic                   valid_out;
    logic                   last_out;

    // Status
    logic                   busy_out;
    logic [COUNT_WIDTH-1:0] byte_count_out;

    modport slave (
        input  enable_in,
        input  len_in,
        input  data_in,
        input  serial_ready_in,
        output dequeue_out,
        output serial_out,
        output valid_out,
        output last_out,
        output busy_out,
        output byte_count_out
    );

    modport master (
        output enable_in,
        output len_in,
        output data_in,
        output serial_ready_in,
        input  dequeue_out,
        input  serial_out,
        input  valid_out,
        input  last_out,
        input  busy_out,
        input  byte_count_out
    );

endinterface

// File: rtl/byte_serializer.sv
// Byte serializer: pulls bytes from a queue head and shifts them out one bit
// per accepted cycle with a valid/ready handshake. Every output is decoded
// from registered state, so reset clears them asynchronously and data_in never
// reaches serial_out combinationally.
module byte_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic             clock_1MHz,
    input  logic             reset,
    byte_serializer_if.slave bus
);

    localparam int unsigned          CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LAST_BIT  = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic [CNT_WIDTH-1:0]   r_bit_cnt;
    logic [COUNT_WIDTH-1:0] r_byte_count;
    logic                   r_armed;

    logic                   w_fetch;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_valid;

    // A byte is available and fetching is permitted.
    assign w_fetch  = bus.enable_in && (bus.len_in != '0);
    assign w_valid  = (r_state == SHIFT);
    assign w_accept = w_valid && bus.serial_ready_in;
    assign w_last   = (r_bit_cnt == LAST_BIT);

    // Held low for the first edge after reset release so the earliest LOAD
    // lands on the second edge.
    always_ff @(posedge clock_1MHz or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clock_1MHz or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; enable_in only gates fetching, never aborts a byte.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_fetch && r_armed) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_state_next = SHIFT;
            end
            SHIFT: begin
                if (w_accept && w_last) begin
                    w_state_next = w_fetch ? LOAD : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Shift register and bit counter: capture in LOAD, advance on accept.
    always_ff @(posedge clock_1MHz or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == LOAD) begin
            r_shift   <= bus.data_in;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_shift   <= MSB_FIRST ? {r_shift[DATA_WIDTH-2:0], 1'b0}
                                   : {1'b0, r_shift[DATA_WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + CNT_WIDTH'(1);
        end
    end

    // Completed-byte counter; wraps naturally at its width.
    always_ff @(posedge clock_1MHz or posedge reset) begin
        if (reset) begin
            r_byte_count <= '0;
        end else if (w_accept && w_last) begin
            r_byte_count <= r_byte_count + COUNT_WIDTH'(1);
        end
    end

    assign bus.dequeue_out    = (r_state == LOAD);
    assign bus.busy_out       = (r_state != IDLE);
    assign bus.valid_out      = w_valid;
    assign bus.last_out       = w_valid && w_last;
    assign bus.serial_out     = w_valid && (MSB_FIRST ? r_shift[DATA_WIDTH-1] : r_shift[0]);
    assign bus.byte_count_out = r_byte_count;

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: an LSB-first and an MSB-first
// instance share one queue model and identical stimulus.
`timescale 1ns/1ps
module tb_byte_serializer;
    import serializer_pkg::*;

    localparam int unsigned DW = 8;

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq_lsb;  // transmitted order, first bit at [7]
        logic [7:0] seq_msb;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          ready = 1'b0;
    logic [7:0]    len_r = 8'd0;
    logic [DW-1:0] data_r = '0;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_valid = 0;
    int   n_deq = 0;
    int   pos = 0;
    int   exp_count = 0;
    logic prev_deq = 1'b0;
    logic pop_pending = 1'b0;

    logic [DW-1:0] q[$];
    logic          acc_l[$];
    logic          acc_m[$];

    byte_serializer_if #(.DATA_WIDTH(DW)) bus_l ();
    byte_serializer_if #(.DATA_WIDTH(DW)) bus_m ();

    assign bus_l.enable_in       = enable;
    assign bus_l.len_in          = len_r;
    assign bus_l.data_in         = data_r;
    assign bus_l.serial_ready_in = ready;
    assign bus_m.enable_in       = enable;
    assign bus_m.len_in          = len_r;
    assign bus_m.data_in         = data_r;
    assign bus_m.serial_ready_in = ready;

    byte_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) dut_l (
        .clock_1MHz(clk),
        .reset     (rst),
        .bus       (bus_l)
    );

    byte_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) dut_m (
        .clock_1MHz(clk),
        .reset     (rst),
        .bus       (bus_m)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic refresh();
        len_r  = 8'(q.size());
        data_r = (q.size() > 0) ? q[0] : '0;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        refresh();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Bit order the sink should see, first bit at [7].
    function automatic logic [7:0] send_order(input logic [7:0] b, input bit msb);
        logic [7:0] s;
        for (int k = 0; k < 8; k++) begin
            s[7-k] = msb ? b[7-k] : b[k];
        end
        return s;
    endfunction

    // Queue model: the head leaves one cycle after the LOAD cycle is observed.
    always @(negedge clk) begin
        if (rst) begin
            pop_pending = 1'b0;
        end else begin
            if (pop_pending && q.size() > 0) begin
                q.delete(0);
            end
            pop_pending = bus_l.dequeue_out;
        end
        refresh();
    end

    // Monitor just before each rising edge: records accepted bits and checks
    // last_out and dequeue spacing against an independent bit position.
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            pos      = 0;
            prev_deq = 1'b0;
        end else begin
            check("lockstep_valid", 32'(bus_m.valid_out), 32'(bus_l.valid_out));
            if (bus_l.valid_out) begin
                n_valid++;
                check("last_l", 32'(bus_l.last_out), 32'(pos == DW - 1));
                check("last_m", 32'(bus_m.last_out), 32'(pos == DW - 1));
            end
            if (bus_l.dequeue_out) begin
                n_deq++;
                check("deq_single", 32'(prev_deq), 32'd0);
            end
            prev_deq = bus_l.dequeue_out;
            if (bus_l.valid_out && ready) begin
                acc_l.push_back(bus_l.serial_out);
                acc_m.push_back(bus_m.serial_out);
                pos = (pos + 1) % DW;
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_deq"},    32'({bus_l.dequeue_out, bus_m.dequeue_out}), 32'd0);
        check({tag, "_valid"},  32'({bus_l.valid_out, bus_m.valid_out}), 32'd0);
        check({tag, "_last"},   32'({bus_l.last_out, bus_m.last_out}), 32'd0);
        check({tag, "_busy"},   32'({bus_l.busy_out, bus_m.busy_out}), 32'd0);
        check({tag, "_serial"}, 32'({bus_l.serial_out, bus_m.serial_out}), 32'd0);
        check({tag, "_count"},  32'(bus_l.byte_count_out | bus_m.byte_count_out), 32'd0);
    endtask

    task automatic check_count(input string tag);
        check({tag, "_count_l"}, 32'(bus_l.byte_count_out), 32'(exp_count[15:0]));
        check({tag, "_count_m"}, 32'(bus_m.byte_count_out), 32'(exp_count[15:0]));
    endtask

    // Tick until both DUTs are idle (and the queue empty when asked).
    task automatic run_idle(input int max_cyc, input bit need_empty, output int busy_cyc);
        bit done;
        done     = 1'b0;
        busy_cyc = 0;
        for (int t = 0; t < max_cyc && !done; t++) begin
            tick();
            if (bus_l.busy_out || bus_m.busy_out) begin
                busy_cyc++;
            end else if (!need_empty || len_r == 8'd0) begin
                done = 1'b1;
            end
        end
        check("idle_reached", 32'(done), 32'd1);
    endtask

    task automatic pop_byte(input string name, input logic [7:0] want_l, input logic [7:0] want_m);
        logic [7:0] bl;
        logic [7:0] bm;
        bl = '0;
        bm = '0;
        check({name, "_nbits"}, 32'(acc_l.size() >= 8 && acc_m.size() >= 8), 32'd1);
        for (int k = 0; k < 8; k++) begin
            if (acc_l.size() > 0) bl = {bl[6:0], acc_l.pop_front()};
            if (acc_m.size() > 0) bm = {bm[6:0], acc_m.pop_front()};
        end
        check({name, "_lsb"}, 32'(bl), 32'(want_l));
        check({name, "_msb"}, 32'(bm), 32'(want_m));
    endtask

    task automatic wait_bits(input int n, input string name);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            if (acc_l.size() >= n) got = 1'b1;
            else tick();
        end
        check(name, 32'(got), 32'd1);
    endtask

    vec_t       vecs[9];
    logic [7:0] sent[$];
    int         bc;
    int         lat;
    int         nd;
    int         nv;
    int         bad;
    logic [7:0] b;

    initial begin
        vecs[0] = '{8'hAA, 8'h55, 8'hAA};
        vecs[1] = '{8'h55, 8'hAA, 8'h55};
        vecs[2] = '{8'hF0, 8'h0F, 8'hF0};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF};
        vecs[4] = '{8'h00, 8'h00, 8'h00};
        vecs[5] = '{8'h01, 8'h80, 8'h01};
        vecs[6] = '{8'h80, 8'h01, 8'h80};
        vecs[7] = '{8'h3C, 8'h3C, 8'h3C};
        vecs[8] = '{8'hC5, 8'hA3, 8'hC5};

        // Reset state, with a byte already waiting in the queue.
        rst    = 1'b1;
        enable = 1'b1;
        ready  = 1'b1;
        push(8'h3C);
        tick();
        check_zero("rst");
        tick();
        tick();
        check_zero("rst_hold");
        rst = 1'b0;
        tick();
        check("first_load_late", 32'(bus_l.dequeue_out), 32'd0);
        run_idle(40, 1'b1, bc);
        check("first_byte_cycles", 32'(bc), 32'd9);
        pop_byte("first_byte", 8'h3C, 8'h3C);
        exp_count = 1;
        check_count("first");

        // Empty queue with enable high: nothing may happen.
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus_l.dequeue_out || bus_l.valid_out || bus_l.busy_out ||
                bus_m.dequeue_out || bus_m.valid_out || bus_m.busy_out) bad++;
        end
        check("empty_quiet", 32'(bad), 32'd0);

        // Table of single bytes: latency, duration, bit order, count.
        for (int i = 0; i < 9; i++) begin
            nd = n_deq;
            push(vecs[i].data);
            lat = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                lat++;
                if (bus_l.valid_out) break;
            end
            check("latency", 32'(lat), 32'd2);
            run_idle(40, 1'b1, bc);
            check("byte_cycles", 32'(lat + bc), 32'd9);
            check("deq_pulses", 32'(n_deq - nd), 32'd1);
            pop_byte("table_byte", vecs[i].seq_lsb, vecs[i].seq_msb);
            exp_count++;
            check_count("table");
        end

        // Back-to-back bytes: one LOAD cycle before each.
        nd = n_deq;
        nv = n_valid;
        push(8'h55);
        push(8'hFF);
        run_idle(60, 1'b1, bc);
        check("b2b_busy", 32'(bc), 32'd18);
        check("b2b_valid", 32'(n_valid - nv), 32'd16);
        check("b2b_deq", 32'(n_deq - nd), 32'd2);
        pop_byte("b2b_first", 8'hAA, 8'h55);
        pop_byte("b2b_second", 8'hFF, 8'hFF);
        exp_count += 2;
        check_count("b2b");

        // Ready stall after the third bit: the fourth bit holds for six cycles.
        push(8'hAA);
        wait_bits(3, "stall_reach");
        ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            check("stall_valid", 32'({bus_l.valid_out, bus_m.valid_out}), 32'd3);
            check("stall_bit_l", 32'(bus_l.serial_out), 32'd1);
            check("stall_bit_m", 32'(bus_m.serial_out), 32'd0);
            check("stall_nbits", 32'(acc_l.size()), 32'd3);
            tick();
        end
        ready = 1'b1;
        check("stall_bit6_l", 32'(bus_l.serial_out), 32'd1);
        check("stall_bit6_m", 32'(bus_m.serial_out), 32'd0);
        run_idle(40, 1'b1, bc);
        pop_byte("stall_byte", 8'h55, 8'hAA);
        exp_count++;
        check_count("stall");

        // Dropping enable mid-byte finishes that byte but blocks the next.
        nd = n_deq;
        push(8'h01);
        push(8'h80);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus_l.valid_out) break;
        end
        enable = 1'b0;
        run_idle(40, 1'b0, bc);
        check("endrop_deq", 32'(n_deq - nd), 32'd1);
        check("endrop_left", 32'(len_r), 32'd1);
        pop_byte("endrop_first", 8'h80, 8'h01);
        exp_count++;
        check_count("endrop");
        enable = 1'b1;
        run_idle(40, 1'b1, bc);
        pop_byte("endrop_second", 8'h01, 8'h80);
        exp_count++;
        check_count("endrop2");

        // Reset after the fourth bit: outputs clear at once, no further bits.
        push(8'hF0);
        wait_bits(4, "rstmid_reach");
        rst = 1'b1;
        #1;
        check_zero("rstmid");
        tick();
        tick();
        rst = 1'b0;
        nv  = n_valid;
        for (int i = 0; i < 20; i++) tick();
        check("rstmid_no_valid", 32'(n_valid - nv), 32'd0);
        check("rstmid_nbits", 32'(acc_l.size()), 32'd4);
        exp_count = 0;
        check_count("rstmid");
        acc_l.delete();
        acc_m.delete();

        // Full queue of 0xFF drained back-to-back.
        nd = n_deq;
        nv = n_valid;
        for (int i = 0; i < 8; i++) push(8'hFF);
        run_idle(200, 1'b1, bc);
        check("full_busy", 32'(bc), 32'd72);
        check("full_deq", 32'(n_deq - nd), 32'd8);
        check("full_valid", 32'(n_valid - nv), 32'd64);
        for (int i = 0; i < 8; i++) pop_byte("full_byte", 8'hFF, 8'hFF);
        exp_count += 8;
        check_count("full");

        // Random traffic against the reference stream model.
        for (int c = 0; c < 400; c++) begin
            if (q.size() < 8 && $urandom_range(0, 2) == 0) begin
                b = 8'($urandom);
                push(b);
                sent.push_back(b);
            end
            enable = ($urandom_range(0, 7) != 0);
            ready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        enable = 1'b1;
        ready  = 1'b1;
        run_idle(400, 1'b1, bc);
        check("rand_nbits", 32'(acc_l.size()), 32'(sent.size() * 8));
        foreach (sent[i]) begin
            pop_byte("rand_byte", send_order(sent[i], 1'b0), send_order(sent[i], 1'b1));
        end
        exp_count += sent.size();
        check_count("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
